// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: frames SCLK with chip-select setup/hold delays and CPOL/CPHA strobes.
// Define SPI_CLKGEN_BACK2BACK_EN to let a go in the final hold cycle chain frames under one cs_n.
module spi_sclk_engine #(
   parameter int C_DIVIDER_WIDTH = 8,
   parameter int C_BITCNT_WIDTH  = 6,
   parameter int C_DELAY_WIDTH   = 4
) (
   input  logic                       sysclk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       go,
   input  logic                       CPOL,
   input  logic                       CPHA,
   input  logic [C_DIVIDER_WIDTH-1:0] divider_i,
   input  logic [C_BITCNT_WIDTH-1:0]  nbits_i,
   input  logic [C_DELAY_WIDTH-1:0]   cs_setup_i,
   input  logic [C_DELAY_WIDTH-1:0]   cs_hold_i,
   output logic                       sclk,
   output logic                       cs_n,
   output logic                       shift_stb,
   output logic                       sample_stb,
   output logic                       busy,
   output logic                       done
);

   localparam int BCW = C_BITCNT_WIDTH + 1;

`ifdef SPI_CLKGEN_BACK2BACK_EN
   localparam bit B2B_EN = 1'b1;
`else
   localparam bit B2B_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

   state_t                     state;
   logic [C_DIVIDER_WIDTH-1:0] div_q;
   logic [C_DIVIDER_WIDTH-1:0] hp_cnt;
   logic [C_DELAY_WIDTH-1:0]   hold_q;
   logic [C_DELAY_WIDTH-1:0]   delay_cnt;
   logic [BCW-1:0]             bit_cnt;
   logic                       cpol_q;
   logic                       cpha_q;
   logic                       lead_next;

   logic [BCW-1:0] nbits_full;
   logic           hp_expire;
   logic           delay_zero;
   logic           last_bit;
   logic           start_ok;

   // nbits_i of zero encodes a full 2^C_BITCNT_WIDTH-bit frame; the extra counter bit holds it.
   assign nbits_full = (nbits_i == '0) ? {1'b1, {C_BITCNT_WIDTH{1'b0}}} : {1'b0, nbits_i};
   assign hp_expire  = (hp_cnt == '0);
   assign delay_zero = (delay_cnt == '0);
   assign last_bit   = (bit_cnt == BCW'(1));
   assign start_ok   = go && enable &&
                       ((state == IDLE) || (B2B_EN && (state == HOLD) && hp_expire && delay_zero));

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state      <= IDLE;
         div_q      <= '0;
         hp_cnt     <= '0;
         hold_q     <= '0;
         delay_cnt  <= '0;
         bit_cnt    <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         lead_next  <= 1'b0;
         sclk       <= CPOL;
         cs_n       <= 1'b1;
         shift_stb  <= 1'b0;
         sample_stb <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // NOTE: one-cycle pulses get a default low here; the branches below override with <=,
         // and the last non-blocking write in program order wins at the edge.
         shift_stb  <= 1'b0;
         sample_stb <= 1'b0;
         done       <= 1'b0;

         if (!enable) begin
            state <= IDLE;
            sclk  <= CPOL;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
         end else if (start_ok) begin
            state     <= SETUP;
            div_q     <= divider_i;
            hp_cnt    <= divider_i;
            delay_cnt <= cs_setup_i;
            hold_q    <= cs_hold_i;
            bit_cnt   <= nbits_full;
            cpol_q    <= CPOL;
            cpha_q    <= CPHA;
            lead_next <= 1'b1;
            sclk      <= CPOL;
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            done      <= (state == HOLD);   // chained frame still reports the previous one
         end else begin
            case (state)
               IDLE: sclk <= CPOL;

               SETUP, HOLD: begin
                  if (!hp_expire) begin
                     hp_cnt <= hp_cnt - 1'b1;
                  end else begin
                     hp_cnt <= div_q;
                     if (!delay_zero) begin
                        delay_cnt <= delay_cnt - 1'b1;
                     end else if (state == SETUP) begin
                        // End of setup is also the first (leading) SCLK edge.
                        state     <= RUN;
                        sclk      <= ~sclk;
                        lead_next <= 1'b0;
                        if (cpha_q) shift_stb  <= 1'b1;
                        else        sample_stb <= 1'b1;
                     end else begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end

               RUN: begin
                  if (!hp_expire) begin
                     hp_cnt <= hp_cnt - 1'b1;
                  end else begin
                     hp_cnt <= div_q;
                     if (lead_next) begin
                        sclk      <= ~sclk;
                        lead_next <= 1'b0;
                        if (cpha_q) shift_stb  <= 1'b1;
                        else        sample_stb <= 1'b1;
                     end else begin
                        lead_next <= 1'b1;
                        if (cpha_q) sample_stb <= 1'b1;
                        if (last_bit) begin
                           // CPHA=0 has no next bit to drive after the final trailing edge.
                           sclk      <= cpol_q;
                           state     <= HOLD;
                           delay_cnt <= hold_q;
                        end else begin
                           sclk    <= ~sclk;
                           bit_cnt <= bit_cnt - 1'b1;
                           if (!cpha_q) shift_stb <= 1'b1;
                        end
                     end
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
